// File: rtl/multdiv_pkg.sv
// Shared types and two's-complement helpers for the iterative multiply/divide unit.
// Helpers work on a fixed-width container; callers pass the live width.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  // Container width for the helpers; covers a 2*WIDTH product for WIDTH up to 64.
  localparam int unsigned MD_MAX_W = 128;

  function automatic logic [MD_MAX_W-1:0] neg_w(input logic [MD_MAX_W-1:0] x,
                                                input int unsigned w);
    logic [MD_MAX_W-1:0] mask;
    mask = {MD_MAX_W{1'b1}} >> (MD_MAX_W - w);
    return (~x + MD_MAX_W'(1)) & mask;
  endfunction

  function automatic logic [MD_MAX_W-1:0] abs_w(input logic [MD_MAX_W-1:0] x,
                                                input int unsigned w);
    logic [MD_MAX_W-1:0] mask;
    logic [MD_MAX_W-1:0] top;
    mask = {MD_MAX_W{1'b1}} >> (MD_MAX_W - w);
    top  = x >> (w - 1);
    return top[0] ? neg_w(x, w) : (x & mask);
  endfunction

endpackage

// File: rtl/multdiv_datapath.sv
// Shift registers, shared WIDTH+1-bit add/sub and iteration counter.
// Multiply: {acc,sh} is the shift-add product; divide: acc is remainder, sh is quotient.
module multdiv_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic             is_mult,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sh,
  output logic             last
);

  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   sum;

  // The partial remainder stays below the divisor (<= 2^(WIDTH-1)), so its top bit is always 0.
  always_comb begin
    shifted = {acc[WIDTH-2:0], sh[WIDTH-1]};
    add_a   = '0;
    add_b   = '0;
    sum     = '0;
    if (is_mult) begin
      add_a = {1'b0, acc};
      add_b = sh[0] ? {1'b0, m} : '0;
      sum   = add_a + add_b;
    end else begin
      add_a = {1'b0, shifted};
      add_b = {1'b0, m};
      sum   = add_a - add_b;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      m   <= '0;
      acc <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
      m   <= is_mult ? mag_a : mag_b;
      sh  <= is_mult ? mag_b : mag_a;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (is_mult) begin
        acc <= sum[WIDTH:1];
        sh  <= {sum[0], sh[WIDTH-1:1]};
      end else if (!sum[WIDTH]) begin
        acc <= sum[WIDTH-1:0];
        sh  <= {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc <= shifted;
        sh  <= {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide; RDY strobes WIDTH+2 cycles after a start edge.
// Optional data_remainder output when MULTDIV_REMAINDER_EN is defined.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state, next_state;
  op_e    op_q;
  logic   sign_a_q, sign_b_q, div_zero_q, div_ovf_q;
  logic   start, load, step, fix, dp_mult, last;
  logic [WIDTH-1:0] mag_a, mag_b, acc, sh;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo, res_nxt;
  logic             exc_nxt;

  assign start = ctrl_MULT | ctrl_DIV;
  assign mag_a = WIDTH'(abs_w(MD_MAX_W'(data_operandA), WIDTH));
  assign mag_b = WIDTH'(abs_w(MD_MAX_W'(data_operandB), WIDTH));

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  // A start edge restarts from any state, discarding whatever was in flight.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ST_RUN;
    end else begin
      unique case (state)
        ST_IDLE: next_state = ST_IDLE;
        ST_RUN:  next_state = last ? ST_FIX : ST_RUN;
        ST_FIX:  next_state = ST_DONE;
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load    = start;
    step    = (state == ST_RUN) && !start;
    fix     = (state == ST_FIX) && !start;
    busy    = (state != ST_IDLE);
    dp_mult = start ? ctrl_MULT : (op_q == OP_MULT);
  end

  multdiv_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .step    (step),
    .is_mult (dp_mult),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc     (acc),
    .sh      (sh),
    .last    (last)
  );

  always_comb begin
    prod    = (sign_a_q ^ sign_b_q) ? PW'(neg_w(MD_MAX_W'({acc, sh}), PW)) : {acc, sh};
    quo     = (sign_a_q ^ sign_b_q) ? WIDTH'(neg_w(MD_MAX_W'(sh), WIDTH)) : sh;
    res_nxt = '0;
    exc_nxt = 1'b0;
    if (op_q == OP_MULT) begin
      res_nxt = prod[WIDTH-1:0];
      exc_nxt = (prod[PW-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    end else if (div_zero_q) begin
      exc_nxt = 1'b1;
    end else if (div_ovf_q) begin
      res_nxt = MIN_VAL;
      exc_nxt = 1'b1;
    end else begin
      res_nxt = quo;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      op_q           <= OP_MULT;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      div_zero_q     <= 1'b0;
      div_ovf_q      <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (state == ST_DONE);
      if (start) begin
        op_q       <= ctrl_MULT ? OP_MULT : OP_DIV;
        sign_a_q   <= data_operandA[WIDTH-1];
        sign_b_q   <= data_operandB[WIDTH-1];
        div_zero_q <= (data_operandB == '0);
        div_ovf_q  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      end
      if (fix) begin
        data_result    <= res_nxt;
        data_exception <= exc_nxt;
      end
    end
  end

`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_nxt;

  always_comb begin
    rem_nxt = '0;
    if (op_q == OP_DIV && !div_zero_q && !div_ovf_q)
      rem_nxt = sign_a_q ? WIDTH'(neg_w(MD_MAX_W'(acc), WIDTH)) : acc;
  end

  always_ff @(posedge clock) begin
    if (!resetn)  data_remainder <= '0;
    else if (fix) data_remainder <= rem_nxt;
  end
`endif

endmodule
